// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the byte-loaded serial adder tile.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit positions of the control pins on uio_in.
    localparam int CTRL_LOAD_A = 0;
    localparam int CTRL_LOAD_B = 1;
    localparam int CTRL_START  = 2;
    localparam int CTRL_NEXT   = 3;

    function automatic int nbytes(input int width);
        return width / 8;
    endfunction

    function automatic int nsteps(input int width, input int bpc);
        return width / bpc;
    endfunction

    function automatic int cnt_w(input int width, input int bpc);
        return (nsteps(width, bpc) > 1) ? $clog2(nsteps(width, bpc)) : 1;
    endfunction

    function automatic int ptr_w(input int width);
        return (nbytes(width) > 1) ? $clog2(nbytes(width)) : 1;
    endfunction

endpackage

// File: rtl/serial_add_slice.sv
// Combinational N-bit ripple-carry full adder: one RUN step of the serial adder.
module serial_add_slice #(
    parameter int N = 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry_chain;

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        carry_chain    = '0;
        sum            = '0;
        carry_chain[0] = cin;
        for (int i = 0; i < N; i++) begin
            sum[i]           = a[i] ^ b[i] ^ carry_chain[i];
            carry_chain[i+1] = (a[i] & b[i]) | (carry_chain[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry_chain[N];

endmodule

// File: rtl/tt_um_serial_adder.sv
// Tile-level serial adder: byte-wise operand load, multi-cycle A+B+cin, byte-wise readout.
module tt_um_serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int NBYTES = nbytes(WIDTH);
    localparam int NSTEPS = nsteps(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W  = cnt_w(WIDTH, BITS_PER_CYCLE);
    localparam int PTR_W  = ptr_w(WIDTH);

    state_t state, state_nx;

    logic [3:0] sync1, sync2, ctrl_q, ctrl_rise;
    logic [WIDTH-1:0] a, b, wa, wb, ws, ws_nx, r, slice_ext;
    logic [BITS_PER_CYCLE-1:0] slice_sum;
    logic slice_cout, carry, cout_q, zero_q;
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] ptr;
    logic start_go, last_step;
    logic unused_pins;

    assign unused_pins = &{1'b0, uio_in[7:4]};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            ctrl_q <= '0;
        end else if (ena) begin
            sync1  <= uio_in[3:0];
            sync2  <= sync1;
            ctrl_q <= sync2;
        end
    end

    assign ctrl_rise = sync2 & ~ctrl_q;
    assign start_go  = ctrl_rise[CTRL_START] && (state != RUN);
    assign last_step = (state == RUN) && (cnt == CNT_W'(NSTEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else if (ena) state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (ctrl_rise[CTRL_START]) state_nx = RUN;
            RUN:        if (last_step) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    serial_add_slice #(.N(BITS_PER_CYCLE)) u_slice (
        .a    (wa[BITS_PER_CYCLE-1:0]),
        .b    (wb[BITS_PER_CYCLE-1:0]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // New sum bits enter at the MSB end, so after NSTEPS shifts the LSBs sit at bit 0.
    assign slice_ext = WIDTH'(slice_sum);
    assign ws_nx     = (ws >> BITS_PER_CYCLE) | (slice_ext << (WIDTH - BITS_PER_CYCLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a      <= '0;
            b      <= '0;
            wa     <= '0;
            wb     <= '0;
            ws     <= '0;
            r      <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
            cnt    <= '0;
            ptr    <= '0;
        end else if (ena) begin
            if (start_go) begin
                wa    <= a;
                wb    <= b;
                ws    <= '0;
                cnt   <= '0;
                carry <= ui_in[0];
            end else if (state != RUN) begin
                if (ctrl_rise[CTRL_LOAD_A]) a <= (a << 8) | WIDTH'(ui_in);
                if (ctrl_rise[CTRL_LOAD_B]) b <= (b << 8) | WIDTH'(ui_in);
            end

            if (state == RUN) begin
                wa    <= wa >> BITS_PER_CYCLE;
                wb    <= wb >> BITS_PER_CYCLE;
                ws    <= ws_nx;
                carry <= slice_cout;
                cnt   <= cnt + 1'b1;
                if (last_step) begin
                    r      <= ws_nx;
                    cout_q <= slice_cout;
                    zero_q <= (ws_nx == '0);
                end
            end

            // Completion rewinds the readout pointer even if next_byte fires on the same edge.
            if (last_step) ptr <= '0;
            else if (ctrl_rise[CTRL_NEXT])
                ptr <= (ptr == PTR_W'(NBYTES - 1)) ? '0 : ptr + 1'b1;
        end
    end

    logic [WIDTH-1:0] r_sel;
    assign r_sel   = r >> {ptr, 3'b000};
    assign uo_out  = r_sel[7:0];
    assign uio_out = {state == RUN, state == DONE, cout_q, zero_q, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: doc/tt_um_serial_adder.md
Name: tt_um_serial_adder

Overview:
Parametrised multi-bit adder that generalises the single-bit half adder. It computes A + B + cin over WIDTH-bit operands using a BITS_PER_CYCLE-wide full-adder slice, iterated over several cycles. Operands are loaded byte-wise through the dedicated input pins, and the result is read back byte-wise. The block sits at the top level behind the standard tile pin interface.

Parameters:
- WIDTH, 8: operand/sum width. Must be a multiple of 8, range 8..32.
- BITS_PER_CYCLE, 1: bits added per RUN cycle. Must divide WIDTH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  design selected. Low freezes all registers.
- ui_in  in  8  operand byte. Bit 0 is also cin, sampled on start.
- uo_out  out  8  selected byte of the result register.
- uio_in  in  8  controls: [0] load_a, [1] load_b, [2] start, [3] next_byte. [7:4] unused.
- uio_out  out  8  [7] busy, [6] done, [5] cout, [4] zero. [3:0] = 0.
- uio_oe  out  8  constant 8'hF0.

Behaviour:
- Reset state: state=IDLE; A, B, shift regs, result R, carry, cnt and ptr all 0; uo_out=0; uio_out=0. uio_oe=8'hF0 at all times.
- Control pins uio_in[3:0]:
  - Each pin passes through a 2-flop synchroniser, then a rising-edge detector.
  - An action takes effect at the 3rd rising clk edge after the pin rise is first sampled.
  - Level-held pins act once only.
- load_a / load_b:
  - A <= {A[WIDTH-9:0], ui_in}; B likewise. Bytes are entered most-significant first.
  - Accepted in IDLE and DONE; ignored in RUN.
  - Both in the same cycle load the same byte into A and B.
- start:
  - Accepted in IDLE or DONE: state<=RUN, cnt<=0, carry<=ui_in[0], done<=0, busy<=1.
  - Working shift regs are copied from A and B; A and B themselves are preserved.
  - Ignored in RUN.
  - If start and load fire in the same cycle, start wins and the load is dropped.
- RUN: each cycle, BITS_PER_CYCLE LSBs of the working regs plus carry feed the slice.
  - Sum bits shift into the working sum from the MSB side.
  - carry <= slice carry-out.
  - cnt increments.
- RUN→DONE at the edge where cnt reaches WIDTH/BITS_PER_CYCLE-1. That edge sets:
  - R <= full sum, cout <= final carry, zero <= (sum==0).
  - busy<=0, done<=1, ptr<=0.
- Latency: start action edge to done=1 is WIDTH/BITS_PER_CYCLE cycles.
- DONE → RUN on a new start. done stays 1 until then.
- next_byte: ptr <= (ptr+1) mod (WIDTH/8), accepted in any state; wraps to 0.
- Outputs:
  - uo_out = R[8*ptr+7 : 8*ptr].
  - R changes only on completion, so uo_out is stable during RUN.
- ena=0: synchroniser, FSM and data registers all hold. Pin edges occurring while ena=0 are lost.
- Asserting rst_n low mid-RUN aborts: everything returns to reset values and no partial result is kept.
- Sum is exactly WIDTH bits. Overflow is reported only through cout (unsigned).

Decomposition:
- Package serial_adder_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - NBYTES = WIDTH/8, NSTEPS = WIDTH/BITS_PER_CYCLE;
  - CNT_W = $clog2(NSTEPS), PTR_W = max(1, $clog2(NBYTES)).
- One sub-module: serial_add_slice, a combinational BITS_PER_CYCLE-bit ripple full adder (a, b, cin -> sum, cout).
- Synchroniser and edge detect stay inline in the top level.

Test Plan:
- WIDTH=8, BPC=1: load A=0x5A, B=0x3C; start with ui_in=0x00 -> busy for 8 cycles, then done=1, uo_out=0x96, cout=0, zero=0.
- WIDTH=8: A=0xFF, B=0x01, cin=0 -> uo_out=0x00, cout=1, zero=1. Then start again with ui_in[0]=1 (A, B retained) -> uo_out=0x01, cout=1, zero=0.
- WIDTH=16, BPC=4: load A bytes 0x12, 0x34 and B bytes 0xFF, 0xFF; start with cin=0 -> done after 4 cycles, result 0x1233, cout=1.
  - Readout: uo_out=0x33; next_byte -> 0x12; next_byte -> 0x33 (wrap).
- During RUN, pulse start and load_a with ui_in=0xAA -> both ignored; result matches the original operands and A is unchanged on the next run.
- Assert rst_n low at the 3rd RUN cycle -> immediately uo_out=0, uio_out=0, state IDLE. The next full run produces the correct sum.
- Hold ena=0 across a load_a pulse -> A is unchanged. Hold ena=0 for 5 cycles mid-RUN -> done is delayed by exactly 5 cycles and the sum is still correct.
